multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle FSM that sequences the RV32I datapath (PC, instruction register, immediate generator, ALU, register file, data memory) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Selects which immediate generator output (I/S/SB/U/UJ) feeds the ALU and PC muxes.
- Drives valid/ready handshakes to instruction and data memory.
- Generates PC, register-file and IR write enables.
- Sits between the memories and the datapath muxes; holds no data registers except a latched opcode.

Parameters:
- XLEN, 32, instruction width; only 32 supported.
- MEM_TIMEOUT, 0, request-wait cycles before mem_timeout asserts; 0 removes the counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  XLEN  instruction memory read data, valid when imem_ready=1
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1=store, 0=load; valid with dmem_req
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  ALU compare result, valid in EXECUTE
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  2  00 pc+4, 01 pc+sb_imm, 10 pc+uj_imm, 11 (rs1+i_imm)&~1
- imm_sel  out  3  0 I, 1 S, 2 SB, 3 U, 4 UJ
- alu_src_a  out  2  00 rs1, 01 pc, 10 zero
- alu_src_b  out  1  0 rs2, 1 immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct3/funct7 decode
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 ALU, 01 memory, 10 pc+4
- mem_timeout  out  1  sticky; request waited MEM_TIMEOUT cycles
- state  out  3  current state, debug

Behaviour:
- Reset: rst is synchronous, active-high. While rst=1, all outputs are forced 0 combinationally. At the clock edge, state<=FETCH (0), opcode register<=0, wait counter<=0, mem_timeout<=0.
- Reset mid-operation: a pending imem_req/dmem_req drops in the same cycle rst rises. No partial reg_write or pc_write occurs.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5 (macro only).
- Outputs are Moore, decoded from state plus latched opcode. All unlisted outputs are 0.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On the imem_ready cycle: ir_write=1, opcode<=instruction[6:0], go to DECODE.
  - Without ready, stay in FETCH; imem_req stays high.
- DECODE: 1 cycle. imm_sel becomes valid and stays stable until the next FETCH:
  - I for 0010011, 0000011, 1100111
  - S for 0100011
  - SB for 1100011
  - U for 0110111, 0010111
  - UJ for 1101111
  - 0 otherwise
- EXECUTE: 1 cycle.
  - R (0110011): a=rs1, b=rs2, op=10.
  - I-ALU: a=rs1, b=imm, op=10.
  - load/store: a=rs1, b=imm, op=00.
  - LUI: a=zero, b=imm.
  - AUIPC: a=pc, b=imm.
  - Branch: op=01, pc_write=1, pc_src=01 if branch_taken else 00, then go to FETCH.
  - Load/store go to MEMORY. All other valid opcodes go to WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_we=1 for a store, held until dmem_ready.
  - On ready: a store asserts pc_write=1, pc_src=00, and goes to FETCH; a load goes to WRITEBACK.
- WRITEBACK: 1 cycle, then FETCH. reg_write=1 and pc_write=1.
  - wb_sel=01 for load, 10 for JAL/JALR, 00 otherwise.
  - pc_src=10 for JAL, 11 for JALR, 00 otherwise.
- Latency per instruction, with zero-wait memories:
  - branch: 3 cycles
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each memory wait cycle adds 1.
- Timeout counter (MEM_TIMEOUT>0):
  - Counts consecutive cycles with a request high and ready low; resets on ready or on a state change.
  - When the count reaches MEM_TIMEOUT, mem_timeout<=1 (sticky until rst).
  - The FSM keeps waiting. The counter saturates.
  - When MEM_TIMEOUT=0, mem_timeout is tied to 0.
- If ready arrives in the same cycle a request first rises, the handshake completes in that cycle.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- With the macro defined:
  - Unrecognised opcodes go DECODE->TRAP.
  - TRAP holds all enables 0 and asserts extra output illegal_instr=1 (1 bit).
  - TRAP is exited only by rst.
- Without the macro:
  - Unrecognised opcodes execute as a NOP: EXECUTE with pc_write=1, pc_src=00, then FETCH.
  - The illegal_instr port is absent.

Test Plan:
- addi x1,x0,5 (0x00500093), zero-wait memories -> states 0,1,2,4,0; imm_sel=0, alu_src_b=1, reg_write=1 and pc_write=1 with pc_src=00 in WRITEBACK.
- sw x1,0(x0) (0x00102023), dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=1 held 4 cycles; imm_sel=1; pc_write=1 on ready cycle; reg_write never 1.
- beq x0,x0,8 (0x00000463), branch_taken=1, then again with branch_taken=0 -> imm_sel=2, pc_src=01 then 00; pc_write=1 in EXECUTE both times; 3-cycle instruction.
- jal x1,16 (0x010000EF) then lw x2,0(x0) (0x00002103) -> JAL: imm_sel=4, wb_sel=10, pc_src=10. LW: dmem_we=0, wb_sel=01, 5-cycle latency.
- MEM_TIMEOUT=4, imem_ready low 6 cycles -> mem_timeout rises after 4 waiting cycles and stays 1 after fetch completes; rst in MEMORY with dmem_req=1 drops dmem_req same cycle and gives state=0 next cycle.
- Opcode 0x7F (0x0000007F) -> without ILLEGAL_TRAP_EN: NOP, pc_write=1, pc_src=00. With it: state=5, illegal_instr=1 until rst.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing of the datapath muxes and enables.
// Latency: branch 3, store/ALU/jump 4, load 5 cycles with zero-wait memories; each memory wait cycle adds one.
// Backpressure: holds imem_req/dmem_req until ready; optional TRAP state via ILLEGAL_TRAP_EN.
module multicycle_controller #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instruction,
    output logic            imem_req,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic            branch_taken,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic [2:0]      imm_sel,
    output logic [1:0]      alu_src_a,
    output logic            alu_src_b,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            mem_timeout,
`ifdef ILLEGAL_TRAP_EN
    output logic            illegal_instr,
`endif
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     cur_state;
    state_t     state_next;
    logic [6:0] opcode_q;
    logic       mem_to_q;

    // Only the opcode field is latched; the datapath keeps its own copy of the full IR.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instruction[XLEN-1:7]};

    logic is_r, is_ialu, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
    logic is_valid;

    always_comb begin
        is_r      = (opcode_q == OP_R);
        is_ialu   = (opcode_q == OP_IALU);
        is_load   = (opcode_q == OP_LOAD);
        is_store  = (opcode_q == OP_STORE);
        is_branch = (opcode_q == OP_BRANCH);
        is_lui    = (opcode_q == OP_LUI);
        is_auipc  = (opcode_q == OP_AUIPC);
        is_jal    = (opcode_q == OP_JAL);
        is_jalr   = (opcode_q == OP_JALR);
        is_valid  = is_r | is_ialu | is_load | is_store | is_branch |
                    is_lui | is_auipc | is_jal | is_jalr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            opcode_q  <= 7'd0;
        end else begin
            cur_state <= state_next;
            if (cur_state == S_FETCH && imem_ready) begin
                opcode_q <= instruction[6:0];
            end
        end
    end

    always_comb begin
        state_next = cur_state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        imm_sel    = 3'd0;
        alu_src_a  = 2'b00;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        mem_timeout = mem_to_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif

        // imm_sel is held from DECODE until the next FETCH so the muxes see a stable immediate.
        if (cur_state != S_FETCH) begin
            if (is_ialu || is_load || is_jalr)  imm_sel = 3'd0;
            else if (is_store)                  imm_sel = 3'd1;
            else if (is_branch)                 imm_sel = 3'd2;
            else if (is_lui || is_auipc)        imm_sel = 3'd3;
            else if (is_jal)                    imm_sel = 3'd4;
        end

        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = is_valid ? S_EXECUTE : S_TRAP;
`else
                state_next = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                if (is_r) begin
                    alu_op     = 2'b10;
                    state_next = S_WRITEBACK;
                end else if (is_ialu) begin
                    alu_src_b  = 1'b1;
                    alu_op     = 2'b10;
                    state_next = S_WRITEBACK;
                end else if (is_load || is_store) begin
                    alu_src_b  = 1'b1;
                    state_next = S_MEMORY;
                end else if (is_lui) begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 1'b1;
                    state_next = S_WRITEBACK;
                end else if (is_auipc) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 1'b1;
                    state_next = S_WRITEBACK;
                end else if (is_branch) begin
                    alu_op     = 2'b01;
                    pc_write   = 1'b1;
                    pc_src     = branch_taken ? 2'b01 : 2'b00;
                    state_next = S_FETCH;
                end else if (is_jal || is_jalr) begin
                    state_next = S_WRITEBACK;
                end else begin
                    // Unrecognised opcode retires as a NOP.
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                state_next = S_FETCH;
                if (is_load)                 wb_sel = 2'b01;
                else if (is_jal || is_jalr)  wb_sel = 2'b10;
                if (is_jal)                  pc_src = 2'b10;
                else if (is_jalr)            pc_src = 2'b11;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                imm_sel       = 3'd0;
                illegal_instr = 1'b1;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Reset gates every output so a request or write never leaks through mid-operation.
        if (rst) begin
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'b00;
            imm_sel     = 3'd0;
            alu_src_a   = 2'b00;
            alu_src_b   = 1'b0;
            alu_op      = 2'b00;
            reg_write   = 1'b0;
            wb_sel      = 2'b00;
            mem_timeout = 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

    assign state = rst ? 3'd0 : cur_state;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] wait_cnt;
            logic          waiting;

            // A wait can only end by ready, which also changes state, so one clear condition covers both.
            assign waiting = (cur_state == S_FETCH  && !imem_ready) ||
                             (cur_state == S_MEMORY && !dmem_ready);

            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_cnt <= '0;
                    mem_to_q <= 1'b0;
                end else if (waiting) begin
                    if (wait_cnt != CW'(MEM_TIMEOUT)) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        mem_to_q <= 1'b1;
                    end
                end else begin
                    wait_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            assign mem_to_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: default-parameter controller plus a MEM_TIMEOUT=4 copy driven by the same stimulus.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, branch_taken;

    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src_b, reg_write, mem_timeout;
    logic [1:0]  pc_src, alu_src_a, alu_op, wb_sel;
    logic [2:0]  imm_sel, state;

    logic        imem_req_t, dmem_req_t, dmem_we_t, ir_write_t, pc_write_t, alu_src_b_t, reg_write_t, mem_timeout_t;
    logic [1:0]  pc_src_t, alu_src_a_t, alu_op_t, wb_sel_t;
    logic [2:0]  imm_sel_t, state_t;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_instr, illegal_instr_t;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .mem_timeout(mem_timeout),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .state(state)
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_req(imem_req_t), .imem_ready(imem_ready),
        .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .ir_write(ir_write_t), .pc_write(pc_write_t),
        .pc_src(pc_src_t), .imm_sel(imm_sel_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
        .alu_op(alu_op_t), .reg_write(reg_write_t), .wb_sel(wb_sel_t), .mem_timeout(mem_timeout_t),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr_t),
`endif
        .state(state_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch: completes the handshake and leaves the DUT in DECODE.
    task automatic fetch(input logic [31:0] instr);
        instruction = instr;
        imem_ready  = 1'b1;
        #1;
        check("fetch_state", state, 0);
        check("fetch_imem_req", imem_req, 1);
        check("fetch_ir_write", ir_write, 1);
        step();
        imem_ready = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; instruction = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_pc_write", pc_write, 0);
        step();
        rst = 1'b0;
        #1;
        check("idle_state", state, 0);
        check("idle_imem_req", imem_req, 1);
        check("idle_ir_write", ir_write, 0);

        // addi x1,x0,5
        fetch(32'h00500093);
        check("addi_dec_state", state, 1);
        check("addi_imm_sel", imm_sel, 0);
        check("addi_dec_pc_write", pc_write, 0);
        step();
        check("addi_ex_state", state, 2);
        check("addi_alu_src_a", alu_src_a, 0);
        check("addi_alu_src_b", alu_src_b, 1);
        check("addi_alu_op", alu_op, 2);
        check("addi_ex_reg_write", reg_write, 0);
        step();
        check("addi_wb_state", state, 4);
        check("addi_reg_write", reg_write, 1);
        check("addi_pc_write", pc_write, 1);
        check("addi_pc_src", pc_src, 0);
        check("addi_wb_sel", wb_sel, 0);
        step();
        check("addi_done_state", state, 0);

        // sw x1,0(x0) with three dmem wait cycles
        fetch(32'h00102023);
        check("sw_imm_sel", imm_sel, 1);
        step();
        check("sw_ex_state", state, 2);
        check("sw_alu_op", alu_op, 0);
        check("sw_alu_src_b", alu_src_b, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", state, 3);
            check("sw_wait_dmem_req", dmem_req, 1);
            check("sw_wait_dmem_we", dmem_we, 1);
            check("sw_wait_pc_write", pc_write, 0);
            check("sw_wait_reg_write", reg_write, 0);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check("sw_rdy_dmem_req", dmem_req, 1);
        check("sw_rdy_dmem_we", dmem_we, 1);
        check("sw_rdy_pc_write", pc_write, 1);
        check("sw_rdy_pc_src", pc_src, 0);
        check("sw_rdy_reg_write", reg_write, 0);
        check("sw_to_below_limit", mem_timeout_t, 0);
        step();
        dmem_ready = 1'b0;
        #1;
        check("sw_done_state", state, 0);

        // beq taken
        fetch(32'h00000463);
        check("beq_imm_sel", imm_sel, 2);
        step();
        branch_taken = 1'b1;
        #1;
        check("beq_t_state", state, 2);
        check("beq_t_alu_op", alu_op, 1);
        check("beq_t_pc_write", pc_write, 1);
        check("beq_t_pc_src", pc_src, 1);
        step();
        branch_taken = 1'b0;
        #1;
        check("beq_t_done_state", state, 0);

        // beq not taken
        fetch(32'h00000463);
        step();
        check("beq_n_pc_write", pc_write, 1);
        check("beq_n_pc_src", pc_src, 0);
        step();
        check("beq_n_done_state", state, 0);

        // jal x1,16
        fetch(32'h010000EF);
        check("jal_imm_sel", imm_sel, 4);
        step();
        check("jal_ex_state", state, 2);
        check("jal_ex_pc_write", pc_write, 0);
        step();
        check("jal_wb_state", state, 4);
        check("jal_wb_sel", wb_sel, 2);
        check("jal_pc_src", pc_src, 2);
        check("jal_reg_write", reg_write, 1);
        step();
        check("jal_done_state", state, 0);

        // lw x2,0(x0), zero-wait: five cycles
        fetch(32'h00002103);
        check("lw_imm_sel", imm_sel, 0);
        step();
        check("lw_alu_op", alu_op, 0);
        step();
        dmem_ready = 1'b1;
        #1;
        check("lw_mem_state", state, 3);
        check("lw_dmem_req", dmem_req, 1);
        check("lw_dmem_we", dmem_we, 0);
        check("lw_mem_pc_write", pc_write, 0);
        step();
        dmem_ready = 1'b0;
        #1;
        check("lw_wb_state", state, 4);
        check("lw_wb_sel", wb_sel, 1);
        check("lw_reg_write", reg_write, 1);
        step();
        check("lw_done_state", state, 0);

        // unrecognised opcode 0x7F
        fetch(32'h0000007F);
        check("ill_dec_state", state, 1);
        step();
`ifdef ILLEGAL_TRAP_EN
        check("ill_trap_state", state, 5);
        check("ill_trap_flag", illegal_instr, 1);
        check("ill_trap_pc_write", pc_write, 0);
        step();
        check("ill_trap_hold", state, 5);
        rst = 1'b1;
        #1;
        check("ill_trap_rst_flag", illegal_instr, 0);
        step();
        rst = 1'b0;
        #1;
        check("ill_trap_exit", state, 0);
`else
        check("ill_nop_state", state, 2);
        check("ill_nop_pc_write", pc_write, 1);
        check("ill_nop_pc_src", pc_src, 0);
        check("ill_nop_reg_write", reg_write, 0);
        step();
        check("ill_nop_done", state, 0);
`endif

        // fetch stall: timeout copy flags after four waiting cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic exp_to;
            exp_to = (i >= 4);
            check("to_wait_state", state_t, 0);
            check("to_wait_flag", mem_timeout_t, exp_to);
            check("to_default_off", mem_timeout, 0);
            step();
        end
        fetch(32'h00002103);
        check("to_sticky", mem_timeout_t, 1);
        step();
        step();
        #1;
        check("rst_mid_dmem_req_pre", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_dmem_req", dmem_req, 0);
        check("rst_mid_dmem_req_t", dmem_req_t, 0);
        check("rst_mid_reg_write", reg_write, 0);
        check("rst_mid_pc_write", pc_write, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_state", state, 0);
        check("rst_mid_state_t", state_t, 0);
        check("rst_clears_to", mem_timeout_t, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
